// File: rtl/complex_mult_pipe.sv
// Pipelined complex multiplier with optional conjugate, scaling shift and saturation.
// Define CMULT_ROUND_EN to round half up before the shift; otherwise the shift truncates.
module complex_mult_pipe #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 17,
  parameter int OUT_WIDTH = 35,
  parameter int SHIFT     = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  input  logic                        i_conj,
  input  logic signed [A_WIDTH-1:0]   i_ar,
  input  logic signed [A_WIDTH-1:0]   i_ai,
  input  logic signed [B_WIDTH-1:0]   i_br,
  input  logic signed [B_WIDTH-1:0]   i_bi,
  input  logic                        i_sat_clr,
  output logic                        o_valid,
  output logic signed [OUT_WIDTH-1:0] o_pr,
  output logic signed [OUT_WIDTH-1:0] o_pi,
  output logic                        o_sat,
  output logic [15:0]                 o_sat_cnt
);

  localparam int PW       = A_WIDTH + B_WIDTH;
  localparam int P        = PW + 1;
  localparam int SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;

  // Scaling works in P+1 bits so the rounding add can never wrap.
`ifdef CMULT_ROUND_EN
  localparam logic signed [P:0] RND = (SHIFT > 0) ? ((P+1)'(1) << SHIFT_M1) : '0;
`else
  localparam logic signed [P:0] RND = '0;
`endif
  localparam logic signed [P:0] MAX_V = {{(P+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [P:0] MIN_V = {{(P+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Returns {clipped, value}.
  function automatic logic [OUT_WIDTH:0] scale(input logic signed [P-1:0] x);
    logic signed [P:0] shf;
    shf = ((P+1)'(x) + RND) >>> SHIFT;
    if (shf > MAX_V)      return {1'b1, OUT_WIDTH'(MAX_V)};
    else if (shf < MIN_V) return {1'b1, OUT_WIDTH'(MIN_V)};
    else                  return {1'b0, OUT_WIDTH'(shf)};
  endfunction

  // Stage 1: input register
  logic                      v1_q, v1_d, conj1_q, conj1_d;
  logic signed [A_WIDTH-1:0] ar1_q, ar1_d, ai1_q, ai1_d;
  logic signed [B_WIDTH-1:0] br1_q, br1_d, bi1_q, bi1_d;
  // Stage 2: partial products
  logic                      v2_q, v2_d, conj2_q, conj2_d;
  logic signed [PW-1:0]      rr_q, rr_d, ii_q, ii_d, ri_q, ri_d, ir_q, ir_d;
  // Stage 3: full-precision sums
  logic                      v3_q, v3_d;
  logic signed [P-1:0]       pr3_q, pr3_d, pi3_q, pi3_d;
  // Stage 4: scaled outputs
  logic                      o_valid_q, o_valid_d, o_sat_q, o_sat_d;
  logic signed [OUT_WIDTH-1:0] o_pr_q, o_pr_d, o_pi_q, o_pi_d;
  logic [15:0]               sat_cnt_q, sat_cnt_d;
  logic [OUT_WIDTH:0]        pr_scaled, pi_scaled;
  logic                      sat_any;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    v1_d    = i_valid;
    conj1_d = i_conj;
    ar1_d   = i_ar;
    ai1_d   = i_ai;
    br1_d   = i_br;
    bi1_d   = i_bi;

    v2_d    = v1_q;
    conj2_d = conj1_q;
    rr_d    = PW'(ar1_q) * PW'(br1_q);
    ii_d    = PW'(ai1_q) * PW'(bi1_q);
    ri_d    = PW'(ar1_q) * PW'(bi1_q);
    ir_d    = PW'(ai1_q) * PW'(br1_q);

    v3_d = v2_q;
    if (conj2_q) begin
      pr3_d = P'(rr_q) + P'(ii_q);
      pi3_d = P'(ir_q) - P'(ri_q);
    end else begin
      pr3_d = P'(rr_q) - P'(ii_q);
      pi3_d = P'(ri_q) + P'(ir_q);
    end

    pr_scaled = scale(pr3_q);
    pi_scaled = scale(pi3_q);
    sat_any   = pr_scaled[OUT_WIDTH] | pi_scaled[OUT_WIDTH];

    o_valid_d = v3_q;
    o_pr_d    = v3_q ? pr_scaled[OUT_WIDTH-1:0] : o_pr_q;
    o_pi_d    = v3_q ? pi_scaled[OUT_WIDTH-1:0] : o_pi_q;
    o_sat_d   = v3_q ? sat_any : o_sat_q;

    // The counter includes the sample being registered; clear has priority.
    sat_cnt_d = sat_cnt_q;
    if (i_sat_clr)
      sat_cnt_d = '0;
    else if (v3_q && sat_any && sat_cnt_q != 16'hFFFF)
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  // NOTE: datapath registers carry no reset; only the valid bits and outputs need a defined value.
  always_ff @(posedge i_clk) begin
    conj1_q <= conj1_d;
    ar1_q   <= ar1_d;
    ai1_q   <= ai1_d;
    br1_q   <= br1_d;
    bi1_q   <= bi1_d;
    conj2_q <= conj2_d;
    rr_q    <= rr_d;
    ii_q    <= ii_d;
    ri_q    <= ri_d;
    ir_q    <= ir_d;
    pr3_q   <= pr3_d;
    pi3_q   <= pi3_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all stages advance together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      o_valid_q <= 1'b0;
      o_pr_q    <= '0;
      o_pi_q    <= '0;
      o_sat_q   <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      o_valid_q <= o_valid_d;
      o_pr_q    <= o_pr_d;
      o_pi_q    <= o_pi_d;
      o_sat_q   <= o_sat_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_pr      = o_pr_q;
  assign o_pi      = o_pi_q;
  assign o_sat     = o_sat_q;
  assign o_sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Bench for complex_mult_pipe: default instance plus a SHIFT=4/OUT_WIDTH=24 instance on shared inputs,
// both checked against a plain-arithmetic reference model with a 4-edge delay line.
module tb_complex_mult_pipe;

`ifdef CMULT_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst_n, i_valid, i_conj, i_sat_clr;
  logic signed [17:0] i_ar, i_ai;
  logic signed [16:0] i_br, i_bi;

  logic               o_valid0, o_sat0;
  logic signed [34:0] o_pr0, o_pi0;
  logic [15:0]        o_sat_cnt0;
  logic               o_valid1, o_sat1;
  logic signed [23:0] o_pr1, o_pi1;
  logic [15:0]        o_sat_cnt1;

  complex_mult_pipe dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_conj(i_conj),
    .i_ar(i_ar), .i_ai(i_ai), .i_br(i_br), .i_bi(i_bi), .i_sat_clr(i_sat_clr),
    .o_valid(o_valid0), .o_pr(o_pr0), .o_pi(o_pi0), .o_sat(o_sat0), .o_sat_cnt(o_sat_cnt0)
  );

  complex_mult_pipe #(.SHIFT(4), .OUT_WIDTH(24)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_conj(i_conj),
    .i_ar(i_ar), .i_ai(i_ai), .i_br(i_br), .i_bi(i_bi), .i_sat_clr(i_sat_clr),
    .o_valid(o_valid1), .o_pr(o_pr1), .o_pi(o_pi1), .o_sat(o_sat1), .o_sat_cnt(o_sat_cnt1)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic   v;
    logic   c;
    longint ar, ai, br, bi;
  } smp_t;

  smp_t   pipe_q[$];
  logic   exp_v;
  longint exp_pr[2], exp_pi[2];
  logic   exp_sat[2];
  int     exp_cnt[2];
  int     tests = 0;
  int     fails = 0;
  int     sh_of[2] = '{0, 4};
  int     ow_of[2] = '{35, 24};

  // Mathematical definition: complex product, optional rounding, floor shift, clip.
  function automatic void ref_out(input smp_t s, input int sh, input int ow,
                                  output longint pr, output longint pi, output logic sat);
    longint raw[2];
    longint hi, lo, x;
    logic   clip;
    if (!s.c) begin
      raw[0] = s.ar * s.br - s.ai * s.bi;
      raw[1] = s.ar * s.bi + s.ai * s.br;
    end else begin
      raw[0] = s.ar * s.br + s.ai * s.bi;
      raw[1] = s.ai * s.br - s.ar * s.bi;
    end
    hi  = (longint'(1) << (ow - 1)) - 1;
    lo  = -(longint'(1) << (ow - 1));
    sat = 1'b0;
    for (int k = 0; k < 2; k++) begin
      x = raw[k];
      if (ROUND && sh > 0) x = x + (longint'(1) << (sh - 1));
      x = x >>> sh;
      clip = (x > hi) || (x < lo);
      if (x > hi) x = hi;
      if (x < lo) x = lo;
      sat = sat | clip;
      if (k == 0) pr = x; else pi = x;
    end
  endfunction

  task automatic model_reset();
    smp_t idle;
    idle = '{v: 1'b0, c: 1'b0, ar: 0, ai: 0, br: 0, bi: 0};
    pipe_q.delete();
    repeat (3) pipe_q.push_back(idle);
    exp_v = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_pr[k] = 0; exp_pi[k] = 0; exp_sat[k] = 1'b0; exp_cnt[k] = 0;
    end
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, settle to posedge+1.
  task automatic step(input logic v, input logic c, input logic clr,
                      input longint ar, input longint ai, input longint br, input longint bi);
    smp_t s, o;
    i_valid = v; i_conj = c; i_sat_clr = clr;
    i_ar = ar[17:0]; i_ai = ai[17:0]; i_br = br[16:0]; i_bi = bi[16:0];
    s.v = v; s.c = c; s.ar = i_ar; s.ai = i_ai; s.br = i_br; s.bi = i_bi;
    @(posedge i_clk);
    pipe_q.push_back(s);
    o = pipe_q.pop_front();
    exp_v = o.v;
    for (int k = 0; k < 2; k++) begin
      if (o.v) ref_out(o, sh_of[k], ow_of[k], exp_pr[k], exp_pi[k], exp_sat[k]);
      if (clr) exp_cnt[k] = 0;
      else if (o.v && exp_sat[k] && exp_cnt[k] < 65535) exp_cnt[k] = exp_cnt[k] + 1;
    end
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, longint'($urandom), longint'($urandom), longint'($urandom), longint'($urandom));
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_conj = 1'b0; i_sat_clr = 1'b0;
    i_ar = '0; i_ai = '0; i_br = '0; i_bi = '0;
    #2;
    tests++;
    if ({o_valid0, o_sat0, o_pr0, o_pi0, o_sat_cnt0, o_valid1, o_sat1, o_pr1, o_pi1, o_sat_cnt1} !== '0) begin
      fails++;
      $display("FAIL reset_state: got v0=%b pr0=%0d pi0=%0d sat0=%b cnt0=%0d v1=%b pr1=%0d cnt1=%0d, want all 0",
               o_valid0, o_pr0, o_pi0, o_sat0, o_sat_cnt0, o_valid1, o_pr1, o_sat_cnt1);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 0) step(1'b1, m[0], 1'b0, 3, 4, 5, -2);
        else idle_step();
        tests++;
        if ({o_valid0, o_sat0, o_pr0, o_pi0, o_sat_cnt0} !==
            {exp_v, exp_sat[0], exp_pr[0][34:0], exp_pi[0][34:0], exp_cnt[0][15:0]}) begin
          fails++;
          $display("FAIL basic conj=%0d cyc=%0d: got v=%b pr=%0d pi=%0d sat=%b cnt=%0d, want v=%b pr=%0d pi=%0d sat=%b cnt=%0d",
                   m, i, o_valid0, o_pr0, o_pi0, o_sat0, o_sat_cnt0, exp_v, exp_pr[0], exp_pi[0], exp_sat[0], exp_cnt[0]);
        end
      end
      tests++;
      if (m == 0 && {o_valid0, o_pr0, o_pi0, o_sat0} !== {1'b1, 35'sd23, 35'sd14, 1'b0}) begin
        fails++;
        $display("FAIL basic_const conj=0: got v=%b pr=%0d pi=%0d sat=%b, want v=1 pr=23 pi=14 sat=0", o_valid0, o_pr0, o_pi0, o_sat0);
      end else if (m == 1 && {o_valid0, o_pr0, o_pi0, o_sat0} !== {1'b1, 35'sd7, 35'sd26, 1'b0}) begin
        fails++;
        $display("FAIL basic_const conj=1: got v=%b pr=%0d pi=%0d sat=%b, want v=1 pr=7 pi=26 sat=0", o_valid0, o_pr0, o_pi0, o_sat0);
      end
    end
  endtask

  // bi=+65536 is outside the 17-bit range, so the same clip (pr=2^34 -> max, pi=0) is reached
  // with representable operands via the conjugate form.
  task automatic test_saturation();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 0) step(1'b1, 1'b1, 1'b0, -131072, -131072, -65536, -65536);
        else step(1'b0, 1'b0, (i == 3) && (m == 1), 0, 0, 0, 0);
        tests++;
        if ({o_valid0, o_sat0, o_pr0, o_pi0, o_sat_cnt0} !==
            {exp_v, exp_sat[0], exp_pr[0][34:0], exp_pi[0][34:0], exp_cnt[0][15:0]}) begin
          fails++;
          $display("FAIL saturation m=%0d cyc=%0d: got v=%b pr=%0d pi=%0d sat=%b cnt=%0d, want v=%b pr=%0d pi=%0d sat=%b cnt=%0d",
                   m, i, o_valid0, o_pr0, o_pi0, o_sat0, o_sat_cnt0, exp_v, exp_pr[0], exp_pi[0], exp_sat[0], exp_cnt[0]);
        end
      end
      tests++;
      if ({o_valid0, o_pr0, o_pi0, o_sat0, o_sat_cnt0} !==
          {1'b1, 35'sd17179869183, 35'sd0, 1'b1, (m == 0) ? 16'd1 : 16'd0}) begin
        fails++;
        $display("FAIL sat_const m=%0d: got v=%b pr=%0d pi=%0d sat=%b cnt=%0d, want v=1 pr=17179869183 pi=0 sat=1 cnt=%0d",
                 m, o_valid0, o_pr0, o_pi0, o_sat0, o_sat_cnt0, (m == 0) ? 1 : 0);
      end
    end
    idle_step();
    tests++;
    if ({o_valid0, o_pr0, o_sat0} !== {1'b0, 35'sd17179869183, 1'b1}) begin
      fails++;
      $display("FAIL sat_hold: got v=%b pr=%0d sat=%b, want v=0 pr=17179869183 sat=1", o_valid0, o_pr0, o_sat0);
    end
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    for (int i = 0; i < 15; i++) begin
      step((i < 8) || (i == 9) || (i == 10), $urandom_range(0, 1), 1'b0,
           longint'($urandom), longint'($urandom), longint'($urandom), longint'($urandom));
      if (o_valid0 === 1'b1) seen++;
      tests++;
      if ({o_valid0, o_sat0, o_pr0, o_pi0, o_sat_cnt0} !==
          {exp_v, exp_sat[0], exp_pr[0][34:0], exp_pi[0][34:0], exp_cnt[0][15:0]}) begin
        fails++;
        $display("FAIL back_to_back cyc=%0d: got v=%b pr=%0d pi=%0d sat=%b cnt=%0d, want v=%b pr=%0d pi=%0d sat=%b cnt=%0d",
                 i, o_valid0, o_pr0, o_pi0, o_sat0, o_sat_cnt0, exp_v, exp_pr[0], exp_pi[0], exp_sat[0], exp_cnt[0]);
      end
    end
    tests++;
    if (seen != 10) begin
      fails++;
      $display("FAIL back_to_back_count: got %0d valid outputs, want 10", seen);
    end
  endtask

  task automatic test_random();
    longint op[4];
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0:       op[k] = (k < 2) ? (($urandom_range(0, 1) == 1) ? 131071 : -131072)
                                   : (($urandom_range(0, 1) == 1) ? 65535 : -65536);
          1:       op[k] = longint'($urandom_range(0, 200)) - 100;
          default: op[k] = longint'($urandom);
        endcase
      end
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 19) == 0,
           op[0], op[1], op[2], op[3]);
      tests++;
      if ({o_valid0, o_sat0, o_pr0, o_pi0, o_sat_cnt0} !==
          {exp_v, exp_sat[0], exp_pr[0][34:0], exp_pi[0][34:0], exp_cnt[0][15:0]}) begin
        fails++;
        $display("FAIL random0 cyc=%0d: got v=%b pr=%0d pi=%0d sat=%b cnt=%0d, want v=%b pr=%0d pi=%0d sat=%b cnt=%0d",
                 i, o_valid0, o_pr0, o_pi0, o_sat0, o_sat_cnt0, exp_v, exp_pr[0], exp_pi[0], exp_sat[0], exp_cnt[0]);
      end
      tests++;
      if ({o_valid1, o_sat1, o_pr1, o_pi1, o_sat_cnt1} !==
          {exp_v, exp_sat[1], exp_pr[1][23:0], exp_pi[1][23:0], exp_cnt[1][15:0]}) begin
        fails++;
        $display("FAIL random1 cyc=%0d: got v=%b pr=%0d pi=%0d sat=%b cnt=%0d, want v=%b pr=%0d pi=%0d sat=%b cnt=%0d",
                 i, o_valid1, o_pr1, o_pi1, o_sat1, o_sat_cnt1, exp_v, exp_pr[1], exp_pi[1], exp_sat[1], exp_cnt[1]);
      end
    end
  endtask

  task automatic test_shift_round();
    logic signed [23:0] want;
    for (int i = 0; i < 5; i++) begin
      if (i < 2) step(1'b1, 1'b0, 1'b0, 1, 0, (i == 0) ? 8 : -8, 0);
      else idle_step();
      tests++;
      if ({o_valid1, o_sat1, o_pr1, o_pi1} !== {exp_v, exp_sat[1], exp_pr[1][23:0], exp_pi[1][23:0]}) begin
        fails++;
        $display("FAIL shift_model cyc=%0d: got v=%b pr=%0d pi=%0d sat=%b, want v=%b pr=%0d pi=%0d sat=%b",
                 i, o_valid1, o_pr1, o_pi1, o_sat1, exp_v, exp_pr[1], exp_pi[1], exp_sat[1]);
      end
      if (i >= 3) begin
        if (i == 3) want = ROUND ? 24'sd1 : 24'sd0;
        else        want = ROUND ? 24'sd0 : -24'sd1;
        tests++;
        if ({o_valid1, o_pr1, o_pi1} !== {1'b1, want, 24'sd0}) begin
          fails++;
          $display("FAIL shift_const cyc=%0d: got v=%b pr=%0d pi=%0d, want v=1 pr=%0d pi=0", i, o_valid1, o_pr1, o_pi1, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid_flight();
    step(1'b1, 1'b0, 1'b0, 1000, -77, 300, 55);
    step(1'b1, 1'b1, 1'b0, -5000, 12, -9, 4000);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    tests++;
    if ({o_valid0, o_sat0, o_pr0, o_pi0, o_sat_cnt0, o_valid1, o_sat1, o_pr1, o_pi1, o_sat_cnt1} !== '0) begin
      fails++;
      $display("FAIL reset_mid: got v0=%b pr0=%0d pi0=%0d sat0=%b cnt0=%0d v1=%b pr1=%0d cnt1=%0d, want all 0",
               o_valid0, o_pr0, o_pi0, o_sat0, o_sat_cnt0, o_valid1, o_pr1, o_sat_cnt1);
    end
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 3) step(1'b1, 1'b0, 1'b0, -42, 17, 99, -3);
      else idle_step();
      tests++;
      if ({o_valid0, o_sat0, o_pr0, o_pi0, o_sat_cnt0} !==
          {exp_v, exp_sat[0], exp_pr[0][34:0], exp_pi[0][34:0], exp_cnt[0][15:0]}) begin
        fails++;
        $display("FAIL reset_recover cyc=%0d: got v=%b pr=%0d pi=%0d sat=%b cnt=%0d, want v=%b pr=%0d pi=%0d sat=%b cnt=%0d",
                 i, o_valid0, o_pr0, o_pi0, o_sat0, o_sat_cnt0, exp_v, exp_pr[0], exp_pi[0], exp_sat[0], exp_cnt[0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_random();
    test_shift_round();
    test_reset_mid_flight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/complex_mult_pipe.md
COMPLEX_MULT_PIPE -- requirements
Module: complex_mult_pipe

Interface
REQ-001 SHALL have parameter A_WIDTH, default 18: signed width of operand A components.
REQ-002 SHALL have parameter B_WIDTH, default 17: signed width of operand B components.
REQ-003 SHALL have parameter OUT_WIDTH, default 35: signed width of each output component.
REQ-004 SHALL have parameter SHIFT, default 0: LSBs discarded from the full-precision result; legal range is OUT_WIDTH+SHIFT <= P, where P = A_WIDTH+B_WIDTH+1.
REQ-005 SHALL have port i_clk, input, width 1: single clock; all logic on the rising edge.
REQ-006 SHALL have port i_rst_n, input, width 1: asynchronous, active-low reset.
REQ-007 SHALL have port i_valid, input, width 1: input sample qualifier.
REQ-008 SHALL have port i_conj, input, width 1: 1 selects A*conj(B); sampled with i_valid.
REQ-009 SHALL have ports i_ar and i_ai, input, width A_WIDTH each: signed real and imaginary parts of A.
REQ-010 SHALL have ports i_br and i_bi, input, width B_WIDTH each: signed real and imaginary parts of B.
REQ-011 SHALL have port i_sat_clr, input, width 1: synchronous clear of the saturation counter.
REQ-012 SHALL have port o_valid, output, width 1: output sample qualifier.
REQ-013 SHALL have ports o_pr and o_pi, output, width OUT_WIDTH each: signed product components.
REQ-014 SHALL have port o_sat, output, width 1: asserted when either component of the current output sample saturated.
REQ-015 SHALL have port o_sat_cnt, output, width 16: count of saturated output samples.

Function
REQ-016 SHALL compute, for i_conj=0, pr = ar*br - ai*bi and pi = ar*bi + ai*br, at full precision P bits.
REQ-017 SHALL compute, for i_conj=1, pr = ar*br + ai*bi and pi = ai*br - ar*bi.
REQ-018 SHALL use a 4-stage pipeline: input register, four products, sum/difference, then round/shift/saturate into the output registers.
REQ-019 SHALL assert o_valid with the matching result exactly 4 clocks after the edge that sampled i_valid=1.
REQ-020 SHALL accept a new sample every clock; there is no backpressure, and output order and gap pattern match the input.
REQ-021 SHALL hold o_pr, o_pi and o_sat at their previous values while o_valid=0.
REQ-022 SHALL arithmetic-right-shift each component by SHIFT; when SHIFT=0, no shift and no rounding is applied.
REQ-023 SHALL saturate each shifted component to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], and set o_sat=1 if either component clipped.
REQ-024 SHALL compute the shift, rounding and saturation in P+1 bits so that no intermediate wraps.
REQ-025 SHALL increment o_sat_cnt by 1 on each cycle where o_valid=1 and o_sat=1, and hold it at 16'hFFFF with no wrap.
REQ-026 SHALL clear o_sat_cnt to 0 on i_sat_clr=1; clear wins over a simultaneous increment.

Reset
REQ-027 SHALL, while i_rst_n=0, immediately force o_valid, o_pr, o_pi, o_sat, o_sat_cnt and all pipeline valid bits to 0.
REQ-028 SHALL discard samples in flight when reset is asserted mid-operation; after release, o_valid stays 0 until 4 clocks after the first new i_valid=1.

Configuration
REQ-029 SHALL, when macro CMULT_ROUND_EN is defined and SHIFT>0, add 2^(SHIFT-1) before the shift (round half up).
REQ-030 SHALL, when CMULT_ROUND_EN is undefined, truncate (floor) with no rounding adder; latency is unchanged either way.

Verification (defaults unless stated)
REQ-031 SHALL cover: ar=3, ai=4, br=5, bi=-2, conj=0 at cycle 0 -> cycle 4: o_valid=1, o_pr=23, o_pi=14, o_sat=0.
REQ-032 SHALL cover: the same operands with conj=1 -> o_pr=7, o_pi=26.
REQ-033 SHALL cover: ar=ai=-131072, br=-65536, bi=65536, conj=0 -> o_pr=17179869183 (saturated), o_pi=0, o_sat=1, o_sat_cnt=1; i_sat_clr on that same cycle -> o_sat_cnt=0.
REQ-034 SHALL cover: 8 back-to-back samples, then 1 idle, then 2 samples -> outputs with an identical valid pattern, in order, each correct.
REQ-035 SHALL cover: SHIFT=4, OUT_WIDTH=24, ar=1, ai=0, bi=0, br=8 then br=-8 -> o_pr=1 then 0 with CMULT_ROUND_EN defined; o_pr=0 then -1 without it.
REQ-036 SHALL cover: i_rst_n low for 1 cycle with 2 samples in flight -> all outputs 0 immediately, and no o_valid until 4 clocks after the next i_valid.
